// File: rtl/des_pkg.sv
// DES S-box tables, P permutation and shared types for the des_sbox_unit slice.
package des_pkg;

    typedef logic [5:0] sbox_idx_t;
    typedef logic [3:0] nibble_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Entry b holds the FIPS value at row {b[5],b[0]}, column b[4:1], so lookups use the raw chunk.
    localparam nibble_t SBOX [8][64] = '{
        '{14, 0, 4,15,13, 7, 1, 4, 2,14,15, 2,11,13, 8, 1, 3,10,10, 6, 6,12,12,11, 5, 9, 9, 5, 0, 3, 7, 8,
           4,15, 1,12,14, 8, 8, 2,13, 4, 6, 9, 2, 1,11, 7,15, 5,12,11, 9, 3, 7,14, 3,10,10, 0, 5, 6, 0,13},
        '{15, 3, 1,13, 8, 4,14, 7, 6,15,11, 2, 3, 8, 4,14, 9,12, 7, 0, 2, 1,13,10,12, 6, 0, 9, 5,11,10, 5,
           0,13,14, 8, 7,10,11, 1,10, 3, 4,15,13, 4, 1, 2, 5,11, 8, 6,12, 7, 6,12, 9, 0, 3, 5, 2,14,15, 9},
        '{10,13, 0, 7, 9, 0,14, 9, 6, 3, 3, 4,15, 6, 5,10, 1, 2,13, 8,12, 5, 7,14,11,12, 4,11, 2,15, 8, 1,
          13, 1, 6,10, 4,13, 9, 0, 8, 6,15, 9, 3, 8, 0, 7,11, 4, 1,15, 2,14,12, 3, 5,11,10, 5,14, 2, 7,12},
        '{ 7,13,13, 8,14,11, 3, 5, 0, 6, 6,15, 9, 0,10, 3, 1, 4, 2, 7, 8, 2, 5,12,11, 1,12,10, 4,14,15, 9,
          10, 3, 6,15, 9, 0, 0, 6,12,10,11, 1, 7,13,13, 8,15, 9, 1, 4, 3, 5,14,11, 5,12, 2, 7, 8, 2, 4,14},
        '{ 2,14,12,11, 4, 2, 1,12, 7, 4,10, 7,11,13, 6, 1, 8, 5, 5, 0, 3,15,15,10,13, 3, 0, 9,14, 8, 9, 6,
           4,11, 2, 8, 1,12,11, 7,10, 1,13,14, 7, 2, 8,13,15, 6, 9,15,12, 0, 5, 9, 6,10, 3, 4, 0, 5,14, 3},
        '{12,10, 1,15,10, 4,15, 2, 9, 7, 2,12, 6, 9, 8, 5, 0, 6,13, 1, 3,13, 4,14,14, 0, 7,11, 5, 3,11, 8,
           9, 4,14, 3,15, 2, 5,12, 2, 9, 8, 5,12,15, 3,10, 7,11, 0,14, 4, 1,10, 7, 1, 6,13, 0,11, 8, 6,13},
        '{ 4,13,11, 0, 2,11,14, 7,15, 4, 0, 9, 8, 1,13,10, 3,14,12, 3, 9, 5, 7,12, 5, 2,10,15, 6, 8, 1, 6,
           1, 6, 4,11,11,13,13, 8,12, 1, 3, 4, 7,10,14, 7,10, 9,15, 5, 6, 0, 8,15, 0,14, 5, 2, 9, 3, 2,12},
        '{13, 1, 2,15, 8,13, 4, 8, 6,10,15, 3,11, 7, 1, 4,10,12, 9, 5, 3, 6,14,11, 5, 0, 0,14,12, 9, 7, 2,
           7, 2,11, 1, 4,14, 1, 7, 9, 4,12,10,14, 8, 2,13, 0,15, 6,12,10, 9,13, 0,15, 3, 3, 5, 5, 6, 8,11}
    };

    // Output bit i (1-based, MSB first) takes input bit P_TABLE[i-1].
    localparam int unsigned P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

endpackage

// File: rtl/des_sbox_rom.sv
// Combinational S-box lookup: one of S1..S8 selected by box_sel, indexed by the raw 6-bit chunk.
module des_sbox_rom
    import des_pkg::*;
(
    input  logic [2:0] box_sel,
    input  sbox_idx_t  idx,
    output nibble_t    nibble
);

    assign nibble = SBOX[box_sel][idx];

endmodule

// File: rtl/des_sbox_unit.sv
// DES S-box substitution stage: 48-bit word through S1..S8 in 8/LANES cycles, valid/ready on both sides.
// Define DES_SBOX_PPERM_EN to present P(S(x)) on out_data instead of the raw S-box nibbles.
module des_sbox_unit
    import des_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int unsigned GROUPS = 8 / LANES;
    localparam int unsigned GW     = $clog2(GROUPS) + 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
    end

    state_t        state;
    logic [GW-1:0] grp;
    logic [47:0]   in_q;
    nibble_t       res_q [8];
    sbox_idx_t     chunk [8];
    logic [2:0]    box_sel [LANES];
    nibble_t       nib [LANES];
    logic [31:0]   sbox_res;

    for (genvar i = 0; i < 8; i++) begin : g_box
        assign chunk[i]               = in_q[47 - 6*i -: 6];
        assign sbox_res[31 - 4*i -: 4] = res_q[i];
    end

    // Lane l handles box grp*LANES + l in the current BUSY cycle.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign box_sel[l] = 3'(32'(grp) * LANES + 32'(l));
        des_sbox_rom u_rom (
            .box_sel (box_sel[l]),
            .idx     (chunk[box_sel[l]]),
            .nibble  (nib[l])
        );
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            grp       <= '0;
            in_q      <= '0;
            for (int i = 0; i < 8; i++) res_q[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= BUSY;
                        in_q  <= in_data;
                        grp   <= '0;
                        for (int i = 0; i < 8; i++) res_q[i] <= '0;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < LANES; l++) res_q[box_sel[l]] <= nib[l];
                    grp <= grp + 1'b1;
                    if (grp == GW'(GROUPS - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DES_SBOX_PPERM_EN
    for (genvar i = 0; i < 32; i++) begin : g_pperm
        assign out_data[31 - i] = sbox_res[5'(32 - P_TABLE[i])];
    end
`else
    assign out_data = sbox_res;
`endif

endmodule

// File: tb/tb_des_sbox_unit.sv
// Bench for des_sbox_unit: four instances (LANES 1/2/4/8) share stimulus; directed and random words.
module tb_des_sbox_unit;

    // Standard FIPS 46-3 tables, row-major (row*16 + col).
    localparam int SB [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

`ifdef DES_SBOX_PPERM_EN
    localparam int PT [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                               2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [47:0] in_data;
    logic        ir [4];
    logic        ov [4];
    logic [31:0] od [4];
    logic [31:0] last_od [4];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_sbox_unit #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_data   (in_data),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_data  (od[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected out_data once the first n boxes have been substituted (rest read 0).
    function automatic logic [31:0] model(input logic [47:0] x, input int n);
        logic [31:0] s;
        logic [5:0]  b;
        int          idx;
`ifdef DES_SBOX_PPERM_EN
        logic [31:0] p;
`endif
        s = '0;
        for (int k = 0; k < n; k++) begin
            b   = x[47 - 6*k -: 6];
            idx = (b[5] ? 32 : 0) + (b[0] ? 16 : 0) + int'(b[4:1]);
            s[31 - 4*k -: 4] = 4'(SB[k][idx]);
        end
`ifdef DES_SBOX_PPERM_EN
        for (int i = 0; i < 32; i++) p[31 - i] = s[5'(32 - PT[i])];
        s = p;
`endif
        return s;
    endfunction

    task automatic run_word(input logic [47:0] x, input int hold, input bit keep_valid);
        int n;
        @(negedge clk);
        for (int g = 0; g < 4; g++) check($sformatf("idle ready L%0d", 1 << g), 32'(ir[g]), 32'd1);
        in_valid = 1'b1;
        in_data  = x;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (keep_valid) in_data = ~x;
            else            in_valid = 1'b0;
            for (int g = 0; g < 4; g++) begin
                n = (c * (1 << g) > 8) ? 8 : c * (1 << g);
                check($sformatf("valid L%0d c%0d", 1 << g, c), 32'(ov[g]), 32'(c >= (8 >> g)));
                check($sformatf("busy ready L%0d c%0d", 1 << g, c), 32'(ir[g]), 32'd0);
                check($sformatf("data L%0d c%0d x=%h", 1 << g, c, x), od[g], model(x, n));
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                check($sformatf("hold valid L%0d", 1 << g), 32'(ov[g]), 32'd1);
                check($sformatf("hold ready L%0d", 1 << g), 32'(ir[g]), 32'd0);
                check($sformatf("hold data L%0d", 1 << g), od[g], model(x, 8));
            end
        end
        for (int g = 0; g < 4; g++) last_od[g] = od[g];
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("release valid L%0d", 1 << g), 32'(ov[g]), 32'd0);
            check($sformatf("release ready L%0d", 1 << g), 32'(ir[g]), 32'd1);
        end
    endtask

    initial begin
        int exp_n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("reset valid L%0d", 1 << g), 32'(ov[g]), 32'd0);
            check($sformatf("reset data L%0d", 1 << g), od[g], 32'd0);
            check($sformatf("reset ready L%0d", 1 << g), 32'(ir[g]), 32'd1);
        end
        rst_n = 1'b1;

        run_word(48'h0, 0, 1'b0);
`ifndef DES_SBOX_PPERM_EN
        check("all-zero L4", last_od[2], 32'hEFA72C4D);
`endif

        run_word(48'hFFFF_FFFF_FFFF, 5, 1'b0);
`ifndef DES_SBOX_PPERM_EN
        for (int g = 0; g < 4; g++) check($sformatf("all-ones L%0d", 1 << g), last_od[g], 32'hD9CE3DCB);
`endif

        for (int b = 0; b < 64; b++) begin
            run_word({6'(b), 42'h0}, 0, 1'b0);
`ifndef DES_SBOX_PPERM_EN
            case (b)
                0:       exp_n = 14;
                1:       exp_n = 0;
                2:       exp_n = 4;
                63:      exp_n = 13;
                default: exp_n = -1;
            endcase
            if (exp_n >= 0) check($sformatf("S1[%0d]", b), 32'(last_od[2][31:28]), 32'(exp_n));
`endif
        end

        // Abort a word mid-BUSY with an asynchronous reset.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 48'hA5A5_5A5A_C3C3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("abort valid L%0d", 1 << g), 32'(ov[g]), 32'd0);
            check($sformatf("abort data L%0d", 1 << g), od[g], 32'd0);
            check($sformatf("abort ready L%0d", 1 << g), 32'(ir[g]), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_word(48'h0123_4567_89AB, 1, 1'b1);

        for (int i = 0; i < 1000; i++)
            run_word({16'($urandom), $urandom}, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
